// File: rtl/spatial_filter_pkg.sv
// Shared constants and types for the spatial filter line-buffer front end.
package spatial_filter_pkg;

  localparam int LINE_W       = 512;
  localparam int NUM_LINE_BUF = 4;
  localparam int PIX_W        = 8;
  localparam int ROW_W        = 3 * PIX_W;
  localparam int WINDOW_W     = 72;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_t;

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage; presents three consecutive pixels at the read pointer.
module line_buffer
  import spatial_filter_pkg::*;
#(
  parameter int DEPTH = spatial_filter_pkg::LINE_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIX_W-1:0]   i_data,
  input  logic               i_data_valid,
  input  logic               i_rd_data_rdy,
  output logic [ROW_W-1:0]   o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p2;

  always_ff @(posedge i_clk) begin
    if (i_data_valid) mem[wr_ptr] <= i_data;
  end

  // Pointers clear synchronously; stored pixels are simply abandoned on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_data_valid)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (i_rd_data_rdy) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // DEPTH is a power of two, so the +1/+2 taps wrap within the line.
  assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
  assign rd_ptr_p2 = rd_ptr + PTR_W'(2);
  assign o_data    = {mem[rd_ptr], mem[rd_ptr_p1], mem[rd_ptr_p2]};

endmodule

// File: rtl/line_buffer_ctrl.sv
// Rotates four line buffers into a registered 3x3 window stream with an end-of-line interrupt.
// state     | meaning
// RD_IDLE   | waiting for three full lines buffered
// RD_ACTIVE | reading one window per cycle for one output line
module line_buffer_ctrl
  import spatial_filter_pkg::*;
#(
  parameter int LINE_W = spatial_filter_pkg::LINE_W,
  parameter int CNT_W  = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PIX_W-1:0]    i_pixel_data,
  input  logic                i_pixel_valid,
  output logic                o_in_ready,
  output logic [WINDOW_W-1:0] o_window,
  output logic                o_window_valid,
  output logic                o_line_done_intr
);

  localparam int PIX_CNT_W = $clog2(LINE_W);
  localparam logic [CNT_W-1:0]     FULL_LVL  = CNT_W'(4 * LINE_W);
  localparam logic [CNT_W-1:0]     START_LVL = CNT_W'(3 * LINE_W);
  localparam logic [PIX_CNT_W-1:0] LAST_PIX  = PIX_CNT_W'(LINE_W - 1);

  rd_state_t              rd_state;
  rd_state_t              rd_state_nxt;
  logic [PIX_CNT_W-1:0]   wr_pix_cnt;
  logic [PIX_CNT_W-1:0]   rd_pix_cnt;
  logic [1:0]             wr_sel;
  logic [1:0]             rd_sel;
  logic [1:0]             rd_sel_p1;
  logic [1:0]             rd_sel_p2;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   wr_en;
  logic                   rd_en;
  logic                   rd_last;
  logic                   buf_rst;
  logic [NUM_LINE_BUF-1:0] buf_wr_en;
  logic [NUM_LINE_BUF-1:0] buf_rd_rdy;
  logic [ROW_W-1:0]        buf_data [NUM_LINE_BUF];
  logic [WINDOW_W-1:0]     window_nxt;

  assign buf_rst    = ~i_rst_n;
  assign o_in_ready = (fill_cnt < FULL_LVL);
  assign wr_en      = i_pixel_valid & o_in_ready;
  assign rd_last    = rd_en && (rd_pix_cnt == LAST_PIX);
  assign rd_sel_p1  = rd_sel + 2'd1;
  assign rd_sel_p2  = rd_sel + 2'd2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_pix_cnt <= '0;
      wr_sel     <= '0;
    end else if (wr_en) begin
      wr_pix_cnt <= wr_pix_cnt + PIX_CNT_W'(1);
      if (wr_pix_cnt == LAST_PIX) wr_sel <= wr_sel + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_cnt <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   fill_cnt <= fill_cnt + CNT_W'(1);
        2'b01:   fill_cnt <= fill_cnt - CNT_W'(1);
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  // Leaving RD_ACTIVE always passes through one RD_IDLE cycle before re-arming.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE:   if (fill_cnt >= START_LVL) rd_state_nxt = RD_ACTIVE;
      RD_ACTIVE: if (rd_pix_cnt == LAST_PIX) rd_state_nxt = RD_IDLE;
      default:   rd_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_en      = 1'b0;
    buf_rd_rdy = '0;
    case (rd_state)
      RD_ACTIVE: begin
        rd_en                 = 1'b1;
        buf_rd_rdy[rd_sel]    = 1'b1;
        buf_rd_rdy[rd_sel_p1] = 1'b1;
        buf_rd_rdy[rd_sel_p2] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_pix_cnt <= '0;
      rd_sel     <= '0;
    end else if (rd_en) begin
      rd_pix_cnt <= rd_pix_cnt + PIX_CNT_W'(1);
      if (rd_last) rd_sel <= rd_sel + 2'd1;
    end
  end

  always_comb begin
    buf_wr_en         = '0;
    buf_wr_en[wr_sel] = wr_en;
  end

  assign window_nxt = {buf_data[rd_sel], buf_data[rd_sel_p1], buf_data[rd_sel_p2]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_window         <= '0;
      o_window_valid   <= 1'b0;
      o_line_done_intr <= 1'b0;
    end else begin
      o_window_valid   <= rd_en;
      o_line_done_intr <= rd_last;
      if (rd_en) o_window <= window_nxt;
    end
  end

  for (genvar g = 0; g < NUM_LINE_BUF; g++) begin : g_buf
    line_buffer #(
      .DEPTH (LINE_W)
    ) u_line_buffer (
      .i_clk         (i_clk),
      .i_rst         (buf_rst),
      .i_data        (i_pixel_data),
      .i_data_valid  (buf_wr_en[g]),
      .i_rd_data_rdy (buf_rd_rdy[g]),
      .o_data        (buf_data[g])
    );
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl: line contents are modelled and expected windows queued per line.
module tb_line_buffer_ctrl;
  import spatial_filter_pkg::*;

  localparam int L = 512;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_pixel_data = '0;
  logic        i_pixel_valid = 1'b0;
  logic        o_in_ready;
  logic [71:0] o_window;
  logic        o_window_valid;
  logic        o_line_done_intr;

  line_buffer_ctrl #(.LINE_W(L), .CNT_W(12)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pixel_data     (i_pixel_data),
    .i_pixel_valid    (i_pixel_valid),
    .o_in_ready       (o_in_ready),
    .o_window         (o_window),
    .o_window_valid   (o_window_valid),
    .o_line_done_intr (o_line_done_intr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [71:0] win;
    logic [71:0] mask;
    logic        last;
  } exp_t;

  exp_t       sb_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  int         lines_written = 0;
  int         valid_cnt = 0;
  int         intr_cnt = 0;
  logic [7:0] line_pix [4][L];

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Output side of the scoreboard: every valid window pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (i_rst_n) begin
        if (o_window_valid) begin
          valid_cnt++;
          vectors++;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_window got=%h required=no window", o_window);
          end else begin
            e = sb_q.pop_front();
            if ((o_window & e.mask) !== (e.win & e.mask)) begin
              miscompares++;
              $display("FAIL window got=%h required=%h (mask %h)", o_window, e.win, e.mask);
            end
            vectors++;
            if (o_line_done_intr !== e.last) begin
              miscompares++;
              $display("FAIL line_done_intr got=%b required=%b", o_line_done_intr, e.last);
            end
          end
        end else if (o_line_done_intr) begin
          vectors++;
          miscompares++;
          $display("FAIL intr_without_valid got=1 required=0");
        end
        if (o_line_done_intr) intr_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_line(input int m);
    exp_t e;
    int   off;
    int   idx;
    for (int c = 0; c < L; c++) begin
      e.win  = '0;
      e.mask = '0;
      for (int r = 0; r < 3; r++) begin
        for (int i = 0; i < 3; i++) begin
          off = (8 - (r * 3 + i)) * 8;
          idx = c + i;
          e.win[off +: 8]  = line_pix[(m + r) % 4][idx % L];
          e.mask[off +: 8] = (idx < L) ? 8'hFF : 8'h00;
        end
      end
      e.last = (c == L - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic write_pixel(input logic [7:0] d);
    int t;
    i_pixel_data  = d;
    i_pixel_valid = 1'b1;
    t = 0;
    while (!o_in_ready && t < 5000) begin
      step();
      t++;
    end
    if (!o_in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout got=0 required=1");
    end
    step();
    last_wr_cyc = cyc;
  endtask

  task automatic write_line(input bit rnd, input bit gap);
    int         k;
    logic [7:0] d;
    k = lines_written;
    for (int c = 0; c < L; c++) begin
      d = rnd ? 8'($urandom) : 8'(k * 16 + c);
      line_pix[k % 4][c] = d;
      write_pixel(d);
      if (gap) begin
        i_pixel_valid = 1'b0;
        step();
      end
    end
    lines_written++;
    if (lines_written >= 3) push_line(lines_written - 3);
  endtask

  task automatic apply_reset();
    i_pixel_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    sb_q.delete();
    lines_written = 0;
    valid_cnt = 0;
    intr_cnt = 0;
    step();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 4 * L) begin
      step();
      t++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got=%0d pending required=0", sb_q.size());
    end
    repeat (4) step();
  endtask

  task automatic check_first_latency(input string name);
    int t;
    t = 0;
    while (!o_window_valid && t < 10) begin
      step();
      t++;
    end
    vectors++;
    if (cyc - last_wr_cyc !== 2) begin
      miscompares++;
      $display("FAIL %s_latency got=%0d required=2 cycles", name, cyc - last_wr_cyc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #1;
    vectors += 4;
    if (o_window !== '0)          begin miscompares++; $display("FAIL rst_window got=%h required=0", o_window); end
    if (o_window_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_valid got=%b required=0", o_window_valid); end
    if (o_line_done_intr !== 1'b0) begin miscompares++; $display("FAIL rst_intr got=%b required=0", o_line_done_intr); end
    if (o_in_ready !== 1'b1)      begin miscompares++; $display("FAIL rst_ready got=%b required=1", o_in_ready); end
    i_rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) write_line(1'b0, 1'b0);
    i_pixel_valid = 1'b1;
    repeat (12) step();
    vectors++;
    if (o_window_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midburst_valid got=%b required=1", o_window_valid);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    vectors += 4;
    if (o_window !== '0)          begin miscompares++; $display("FAIL async_rst_window got=%h required=0", o_window); end
    if (o_window_valid !== 1'b0)  begin miscompares++; $display("FAIL async_rst_valid got=%b required=0", o_window_valid); end
    if (o_line_done_intr !== 1'b0) begin miscompares++; $display("FAIL async_rst_intr got=%b required=0", o_line_done_intr); end
    if (o_in_ready !== 1'b1)      begin miscompares++; $display("FAIL async_rst_ready got=%b required=1", o_in_ready); end
    i_pixel_valid = 1'b0;
    apply_reset();
  endtask

  task automatic test_ramp();
    for (int k = 0; k < 3; k++) write_line(1'b0, 1'b0);
    i_pixel_valid = 1'b0;
    check_first_latency("ramp");
    drain();
    vectors += 2;
    if (valid_cnt !== L) begin miscompares++; $display("FAIL ramp_valid_count got=%0d required=%0d", valid_cnt, L); end
    if (intr_cnt !== 1)  begin miscompares++; $display("FAIL ramp_intr_count got=%0d required=1", intr_cnt); end
  endtask

  task automatic test_rotation();
    apply_reset();
    for (int k = 0; k < 6; k++) write_line(1'b0, 1'b0);
    i_pixel_valid = 1'b0;
    drain();
    vectors += 2;
    if (intr_cnt !== 4)      begin miscompares++; $display("FAIL rotation_intr_count got=%0d required=4", intr_cnt); end
    if (valid_cnt !== 4 * L) begin miscompares++; $display("FAIL rotation_valid_count got=%0d required=%0d", valid_cnt, 4 * L); end
  endtask

  task automatic test_simul_rw();
    int bad_fill;
    apply_reset();
    bad_fill = -1;
    fork
      begin
        for (int k = 0; k < 4; k++) write_line(1'b0, 1'b0);
        i_pixel_valid = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (!o_window_valid && t < 5 * L) begin
          step();
          t++;
        end
        for (int n = 0; n < L - 1; n++) begin
          if (bad_fill < 0 && int'(dut.fill_cnt) != 3 * L + 1) bad_fill = int'(dut.fill_cnt);
          step();
        end
      end
    join
    drain();
    vectors++;
    if (bad_fill >= 0) begin
      miscompares++;
      $display("FAIL burst_fill_constant got=%0d required=%0d", bad_fill, 3 * L + 1);
    end
  endtask

  task automatic test_full();
    apply_reset();
    force dut.rd_state = RD_IDLE;
    for (int n = 0; n < 4 * L; n++) write_pixel(8'(n));
    vectors += 2;
    if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got=%b required=0", o_in_ready); end
    if (int'(dut.fill_cnt) != 4 * L) begin miscompares++; $display("FAIL full_fill got=%0d required=%0d", dut.fill_cnt, 4 * L); end
    i_pixel_data  = 8'hEE;
    i_pixel_valid = 1'b1;
    repeat (3) step();
    vectors += 4;
    if (int'(dut.fill_cnt) != 4 * L) begin miscompares++; $display("FAIL full_extra_fill got=%0d required=%0d", dut.fill_cnt, 4 * L); end
    if (dut.wr_pix_cnt !== '0) begin miscompares++; $display("FAIL full_extra_wr_pix got=%0d required=0", dut.wr_pix_cnt); end
    if (dut.wr_sel !== 2'd0)   begin miscompares++; $display("FAIL full_extra_wr_sel got=%0d required=0", dut.wr_sel); end
    if (o_window_valid !== 1'b0) begin miscompares++; $display("FAIL full_held_valid got=%b required=0", o_window_valid); end
    i_pixel_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    release dut.rd_state;
    apply_reset();
  endtask

  task automatic test_gapped();
    apply_reset();
    for (int k = 0; k < 3; k++) write_line(1'b1, 1'b1);
    i_pixel_valid = 1'b0;
    check_first_latency("gapped");
    drain();
    vectors += 2;
    if (valid_cnt !== L) begin miscompares++; $display("FAIL gapped_valid_count got=%0d required=%0d", valid_cnt, L); end
    if (intr_cnt !== 1)  begin miscompares++; $display("FAIL gapped_intr_count got=%0d required=1", intr_cnt); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_rotation();
    test_simul_rw();
    test_full();
    test_gapped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
